reg_file_mp: RTL
================

// Module: reg_file_mp
// PURPOSE
//   Multi-read-port, single-write-port register file for the RISC-V core datapath.
//   Provides NRP independent registered read ports and one write port.
//   Optional write-to-read bypass and an optional hardwired-zero register 0.
//   Built-in clear sequencer zeroes the array after reset or on request.
// PARAMETERS
//   ADW       5   address width; DEPTH = 2**ADW entries
//   DPW       32  data width in bits
//   NRP       2   number of read ports (1..4)
//   BYPASS    1   1: same-cycle write data is forwarded to a matching read; 0: read returns the old value
//   ZERO_REG  1   1: entry 0 always reads 0 and ignores writes (RISC-V x0)
// PORTS
//   clk_i      in   1          clock; all state updates on the rising edge
//   arst_i     in   1          asynchronous active-high reset
//   clr_i      in   1          single-cycle request to start a full-array clear
//   busy_o     out  1          1 while the clear sequencer runs
//   rd_en_i    in   NRP        per-port read enable
//   rd_addr_i  in   NRP*ADW    read addresses; port k uses bits [k*ADW +: ADW]
//   rd_data_o  out  NRP*DPW    registered read data; port k uses bits [k*DPW +: DPW]
//   we_i       in   1          write enable
//   wr_addr_i  in   ADW        write address
//   wr_data_i  in   DPW        write data
// BEHAVIOUR
//   Reset (async, on arst_i high):
//     rd_data_o=0, busy_o=1, FSM=CLEAR, clear pointer=0.
//     Array contents are not reset directly; the sequencer zeroes them.
//   FSM, two states:
//     CLEAR: each cycle writes 0 to regs[ptr] and increments ptr.
//       After the write to DEPTH-1 -> IDLE; busy_o=0 from that next cycle.
//       A clear takes exactly DEPTH cycles.
//     IDLE: on clr_i=1 -> CLEAR next cycle, ptr=0, busy_o=1 next cycle.
//   While in CLEAR:
//     we_i is dropped (no write); rd_data_o is driven to 0 on every edge.
//     clr_i is ignored (no restart).
//   Reset asserted mid-clear: the clear restarts from ptr=0.
//   Read latency: 1 cycle.
//     In IDLE, if rd_en_i[k]=1 then rd_data_o[k] <= regs[rd_addr_k] at the edge.
//     If rd_en_i[k]=0, port k holds its last value.
//   Write: in IDLE, if we_i=1 then regs[wr_addr_i] <= wr_data_i at the edge.
//   Bypass (BYPASS=1):
//     Condition: we_i=1, wr_addr_i==rd_addr_k, rd_en_i[k]=1, and the write is not suppressed.
//     Result: rd_data_o[k] <= wr_data_i.
//     Several ports on the same address all receive the bypassed data.
//   BYPASS=0: a read of the entry being written returns the pre-write value.
//   ZERO_REG=1:
//     Writes to address 0 are discarded.
//     Reads of address 0 return 0, even with a matching write in the same cycle.
//   clr_i and we_i together in IDLE: clr_i wins and the write is dropped.
//     Reads in that cycle are still serviced normally.
//   Any number of read ports may target the same address; no port conflicts.
// TESTING
//   1. Reset: assert arst_i, then release it.
//      -> rd_data_o=0 immediately.
//      -> busy_o=1 for exactly 32 cycles, then 0.
//      -> All 32 entries then read 0.
//   2. Write/read: write 0xDEADBEEF to entry 5.
//      Next cycle, read entry 5 on port 0 and port 1.
//      -> Both ports show 0xDEADBEEF one cycle after the read.
//   3. Bypass: entry 7 holds 0x11.
//      In one cycle, write 0x22 to entry 7 and read entry 7.
//      -> BYPASS=1: read returns 0x22.
//      -> BYPASS=0: read returns 0x11; a later read returns 0x22.
//   4. Zero register (ZERO_REG=1): write 0xFFFFFFFF to entry 0 and read entry 0 in the same cycle.
//      -> Read returns 0, both in that cycle and afterwards.
//   5. Soft clear: fill entries 1..31 with their index.
//      Pulse clr_i together with we_i (entry 3 = 0xAA).
//      -> busy_o=1 for 32 cycles; writes and reads issued during the clear have no effect.
//      -> Afterwards every entry reads 0, including entry 3.
//   6. Reset mid-clear: pulse clr_i; at clear cycle 10 pulse arst_i.
//      -> busy_o stays high for 32 further cycles after reset release.
//      -> Then all entries read 0; rd_en_i=0 holds the last read value.

Source files
------------

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-read-port register file with clear sequencer and write bypass
module reg_file_mp #(
    parameter int ADW      = 5,
    parameter int DPW      = 32,
    parameter int NRP      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic               clk_i,
    input  logic               arst_i,
    input  logic               clr_i,
    output logic               busy_o,
    input  logic [NRP-1:0]     rd_en_i,
    input  logic [NRP*ADW-1:0] rd_addr_i,
    output logic [NRP*DPW-1:0] rd_data_o,
    input  logic               we_i,
    input  logic [ADW-1:0]     wr_addr_i,
    input  logic [DPW-1:0]     wr_data_i
);

    localparam int DEPTH = 2 ** ADW;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADW-1:0]     r_ptr;
    logic [ADW-1:0]     w_ptr_nxt;
    logic [DPW-1:0]     r_regs [DEPTH];
    logic [NRP*DPW-1:0] r_rd_data;
    logic [NRP*DPW-1:0] w_rd_data_nxt;
    logic [ADW-1:0]     w_rd_addr [NRP];
    logic               w_wr_ok;
    logic               w_idle;

    for (genvar k = 0; k < NRP; k++) begin : g_addr
        assign w_rd_addr[k] = rd_addr_i[k*ADW +: ADW];
    end

    assign w_idle  = (r_state == S_IDLE);
    // A write lands only in IDLE, loses to a clear request, and never touches x0
    assign w_wr_ok = w_idle && we_i && !clr_i &&
                     !((ZERO_REG != 0) && (wr_addr_i == '0));
    assign busy_o    = (r_state == S_CLEAR);
    assign rd_data_o = r_rd_data;

    // Sequencer state and clear pointer; reset always restarts the clear from entry 0
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Next-state: walk every entry once, then idle until a clear request
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_CLEAR: begin
                w_ptr_nxt = r_ptr + ADW'(1);
                if (r_ptr == ADW'(DEPTH - 1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (clr_i) begin
                    w_state_nxt = S_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_CLEAR;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    // Storage array: no reset of its own, the sequencer zeroes it
    always_ff @(posedge clk_i) begin
        if (r_state == S_CLEAR) begin
            r_regs[r_ptr] <= '0;
        end else if (w_wr_ok) begin
            r_regs[wr_addr_i] <= wr_data_i;
        end
    end

    // Per-port read data selection: zero during clear, x0 forced to zero, then bypass, then array
    always_comb begin
        w_rd_data_nxt = r_rd_data;
        for (int k = 0; k < NRP; k++) begin
            if (!w_idle) begin
                w_rd_data_nxt[k*DPW +: DPW] = '0;
            end else if (rd_en_i[k]) begin
                if ((ZERO_REG != 0) && (w_rd_addr[k] == '0)) begin
                    w_rd_data_nxt[k*DPW +: DPW] = '0;
                end else if ((BYPASS != 0) && w_wr_ok && (w_rd_addr[k] == wr_addr_i)) begin
                    w_rd_data_nxt[k*DPW +: DPW] = wr_data_i;
                end else begin
                    w_rd_data_nxt[k*DPW +: DPW] = r_regs[w_rd_addr[k]];
                end
            end
        end
    end

    // Registered read outputs; disabled ports keep their last value
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_data_nxt;
        end
    end

endmodule
